// File: rtl/mcbsp_arb_pkg.sv
// Shared types and constants for the McBSP transmit arbiter.
// Holds the arbiter FSM state encoding, datapath widths and the
// word-length clamp used when a frame is granted.
package mcbsp_arb_pkg;

  localparam int TIMER_W         = 17;
  localparam int NUMBER_W        = 9;
  localparam int LENGTH_W        = 7;
  localparam int DATA_W          = 32;
  localparam int LEN_MIN_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    FRAME = 3'd3,
    GAP   = 3'd4
  } arb_state_e;

  // Word lengths below the master's minimum are raised to that minimum.
  function automatic logic [LENGTH_W-1:0] clamp_length(
    input logic [LENGTH_W-1:0] len,
    input logic [LENGTH_W-1:0] len_min
  );
    return (len < len_min) ? len_min : len;
  endfunction

endpackage

// File: rtl/mcbsp_rr_picker.sv
// Request picker for the McBSP transmit arbiter.
// Turns a request vector into a one-hot winner. The default build does a
// round-robin search starting at ptr_i; defining MCBSP_ARB_FIXED_PRIO_EN
// switches to fixed priority (lowest index wins) and ignores the pointer.
module mcbsp_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  assign valid_o = |req_i;

`ifdef MCBSP_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0] unused_ptr;
  assign unused_ptr = ptr_i;

  // Lowest set request bit wins.
  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[k]) begin
        gnt_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] gnt_rot;

  // Rotate so the pointer position becomes bit 0, pick lowest, rotate back.
  always_comb begin
    logic found;
    found   = 1'b0;
    gnt_rot = '0;
    req_rot = NUM_REQ'({req_i, req_i} >> ptr_i);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        gnt_rot[k] = 1'b1;
        found      = 1'b1;
      end
    end
    gnt_o = NUM_REQ'(({gnt_rot, gnt_rot} << ptr_i) >> NUM_REQ);
  end
`endif

endmodule

// File: rtl/mcbsp_tx_arbiter.sv
// McBSP transmit arbiter: shares one serial master among NUM_REQ frame
// requesters. Picks a winner, latches its frame length and clamped word
// length, pulses the master enable, times the frame and then enforces an
// idle gap. Master update pulses are forwarded as RAM read strobes to the
// granted requester, capped at the frame's word count.
// Build option: MCBSP_ARB_FIXED_PRIO_EN selects fixed priority in the picker.
module mcbsp_tx_arbiter
  import mcbsp_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 4,
  parameter int LEN_MIN    = LEN_MIN_DEFAULT
) (
  input  logic                        mcbsp_clk_in,
  input  logic                        mcbsp_rst_n_in,
  input  logic [LENGTH_W-1:0]         cfg_length,
  input  logic [NUM_REQ-1:0]          req_in,
  input  logic [NUMBER_W*NUM_REQ-1:0] req_number_in,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data_in,
  output logic [NUM_REQ-1:0]          req_rd_en_out,
  output logic [NUM_REQ-1:0]          req_done_out,
  output logic [NUM_REQ-1:0]          req_err_out,
  input  logic                        mst_update_in,
  output logic                        mst_en_out,
  output logic [NUMBER_W-1:0]         mst_number_out,
  output logic [LENGTH_W-1:0]         mst_length_out,
  output logic [DATA_W-1:0]           mst_data_out,
  output logic                        busy_out,
  output logic [NUM_REQ-1:0]          grant_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [NUMBER_W-1:0] word_q, word_d;
  logic [NUMBER_W-1:0] number_q, number_d;
  logic [LENGTH_W-1:0] length_q, length_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic                pick_valid;
  logic [NUMBER_W-1:0] pick_number;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    ptr_next;
  logic [TIMER_W-1:0]  frame_cycles;
  logic                fwd_upd;
  logic                reject;
  logic                frame_end;

  mcbsp_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i   (req_in),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // Frame length of the requester the picker currently favours.
  always_comb begin
    pick_number = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_number = req_number_in[NUMBER_W*i +: NUMBER_W];
    end
  end

  // Index and data of the granted requester; data is 0 with no grant.
  always_comb begin
    grant_idx    = '0;
    mst_data_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        grant_idx    = PTR_W'(i);
        mst_data_out = req_data_in[DATA_W*i +: DATA_W];
      end
    end
  end

  assign ptr_next     = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  assign frame_cycles = (TIMER_W'(number_q) + TIMER_W'(2)) * TIMER_W'(length_q);
  assign fwd_upd      = (state_q == FRAME) && mst_update_in && (word_q < number_q);
  assign reject       = (state_q == GRANT) && (number_q == '0);
  assign frame_end    = (state_q == FRAME) && (timer_q == '0);

  assign req_rd_en_out  = grant_q & {NUM_REQ{fwd_upd}};
  assign req_done_out   = grant_q & {NUM_REQ{reject | frame_end}};
  assign req_err_out    = grant_q & {NUM_REQ{reject}};
  assign mst_en_out     = (state_q == START);
  assign mst_number_out = number_q;
  assign mst_length_out = length_q;
  assign busy_out       = (state_q != IDLE);
  assign grant_out      = grant_q;

  // Next-state logic: grant, start, frame timing and the post-frame gap.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    word_d   = word_q;
    number_d = number_q;
    length_d = length_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = GRANT;
          grant_d  = pick_gnt;
          number_d = pick_number;
          length_d = clamp_length(cfg_length, LENGTH_W'(LEN_MIN));
          word_d   = '0;
        end
      end
      GRANT: begin
        if (number_q == '0) begin
          // Empty frame: acknowledge with an error, skip the master.
          state_d = GAP;
          timer_d = TIMER_W'(GAP_CYCLES - 1);
          grant_d = '0;
          ptr_d   = ptr_next;
        end else begin
          state_d = START;
        end
      end
      START: begin
        state_d = FRAME;
        timer_d = frame_cycles - TIMER_W'(1);
      end
      FRAME: begin
        if (fwd_upd) word_d = word_q + NUMBER_W'(1);
        if (timer_q == '0) begin
          state_d = GAP;
          timer_d = TIMER_W'(GAP_CYCLES - 1);
          grant_d = '0;
          ptr_d   = ptr_next;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      GAP: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset mid-frame drops everything without a done pulse.
  always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      word_q   <= '0;
      number_q <= '0;
      length_q <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      word_q   <= word_d;
      number_q <= number_d;
      length_q <= length_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mcbsp_tx_arbiter.sv
// Directed bench for mcbsp_tx_arbiter: single frame timing and read strobes,
// reset during a frame, four-way arbitration order, empty-frame rejection
// and word-length clamping. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_mcbsp_tx_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 4;

  logic               clk;
  logic               rst_n;
  logic [6:0]         cfg_length;
  logic [NREQ-1:0]    req_in;
  logic [9*NREQ-1:0]  req_number_in;
  logic [32*NREQ-1:0] req_data_in;
  logic [NREQ-1:0]    req_rd_en_out;
  logic [NREQ-1:0]    req_done_out;
  logic [NREQ-1:0]    req_err_out;
  logic               mst_update_in;
  logic               mst_en_out;
  logic [8:0]         mst_number_out;
  logic [6:0]         mst_length_out;
  logic [31:0]        mst_data_out;
  logic               busy_out;
  logic [NREQ-1:0]    grant_out;

  int cmp_cnt = 0;
  int err_cnt = 0;

  mcbsp_tx_arbiter #(
    .NUM_REQ    (NREQ),
    .GAP_CYCLES (GAP),
    .LEN_MIN    (8)
  ) dut (
    .mcbsp_clk_in   (clk),
    .mcbsp_rst_n_in (rst_n),
    .cfg_length     (cfg_length),
    .req_in         (req_in),
    .req_number_in  (req_number_in),
    .req_data_in    (req_data_in),
    .req_rd_en_out  (req_rd_en_out),
    .req_done_out   (req_done_out),
    .req_err_out    (req_err_out),
    .mst_update_in  (mst_update_in),
    .mst_en_out     (mst_en_out),
    .mst_number_out (mst_number_out),
    .mst_length_out (mst_length_out),
    .mst_data_out   (mst_data_out),
    .busy_out       (busy_out),
    .grant_out      (grant_out)
  );

  // 20 MHz clock
  initial clk = 1'b0;
  always #25 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a grant, checks latched values, enable, frame length and gap.
  // Flips cfg_length mid-frame to confirm the latched length does not follow.
  task automatic run_frame(input string tag, input logic [NREQ-1:0] exp_gnt,
                           input logic [31:0] exp_data, input int exp_num,
                           input int exp_len, input int exp_cycles, input bit drop);
    int n;
    bit seen;
    n = 0;
    while (grant_out == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant"},  32'(grant_out), 32'(exp_gnt));
    chk({tag, "_number"}, 32'(mst_number_out), 32'(exp_num));
    chk({tag, "_length"}, 32'(mst_length_out), 32'(exp_len));
    chk({tag, "_data"},   mst_data_out, exp_data);
    if (drop) req_in = '0;
    @(negedge clk);
    chk({tag, "_en"}, 32'(mst_en_out), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 10) cfg_length = cfg_length ^ 7'h55;
      seen = (req_done_out != '0);
    end
    chk({tag, "_done"},     32'(req_done_out), 32'(exp_gnt));
    chk({tag, "_cycles"},   32'(n), 32'(exp_cycles));
    chk({tag, "_len_hold"}, 32'(mst_length_out), 32'(exp_len));
    n = 0;
    while (busy_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_gap"}, 32'(n), 32'(GAP + 1));
  endtask

  initial begin
    int done_at;
    int done_cnt;
    int rd_cnt;
    int rd_bad;
    int err_pulses;
    logic [NREQ-1:0] done_val;
    logic [6:0] len_mid;
    logic busy_gap, busy_idle, en_seen;
    logic [NREQ-1:0] gnt_gap;
    logic [NREQ-1:0] exp_order [4];

    // ---- reset ----
    rst_n         = 1'b0;
    cfg_length    = 7'd32;
    req_in        = '0;
    mst_update_in = 1'b0;
    req_number_in = '0;
    req_data_in   = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    repeat (3) @(negedge clk);
    chk("rst_grant",  32'(grant_out), 32'd0);
    chk("rst_busy",   32'(busy_out), 32'd0);
    chk("rst_en",     32'(mst_en_out), 32'd0);
    chk("rst_number", 32'(mst_number_out), 32'd0);
    chk("rst_length", 32'(mst_length_out), 32'd0);
    chk("rst_data",   mst_data_out, 32'd0);
    chk("rst_done",   32'(req_done_out | req_err_out | req_rd_en_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- single request: number 3, length 32 -> 160-clock frame ----
    req_number_in[8:0] = 9'd3;
    cfg_length         = 7'd32;
    req_in             = 4'b0001;
    @(negedge clk);
    chk("t1_grant",  32'(grant_out), 32'h1);
    chk("t1_number", 32'(mst_number_out), 32'd3);
    chk("t1_length", 32'(mst_length_out), 32'd32);
    chk("t1_data",   mst_data_out, 32'hA0A0_0000);
    chk("t1_busy",   32'(busy_out), 32'd1);
    chk("t1_en_lat1", 32'(mst_en_out), 32'd0);
    @(negedge clk);
    chk("t1_en_lat2", 32'(mst_en_out), 32'd1);
    req_in   = '0;
    done_at  = -1;
    done_cnt = 0;
    done_val = '0;
    rd_cnt   = 0;
    rd_bad   = 0;
    len_mid  = '0;
    busy_gap = 1'b0;
    busy_idle = 1'b1;
    gnt_gap  = '1;
    for (int c = 1; c <= 170; c++) begin
      @(negedge clk);
      mst_update_in = (c <= 80) && (c % 20 == 5);
      if (c == 50) cfg_length = 7'd10;
      #1;
      if (req_rd_en_out == 4'b0001) rd_cnt++;
      else if (req_rd_en_out != '0) rd_bad++;
      if (req_done_out != '0) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
        done_val = req_done_out;
      end
      if (c == 100) len_mid = mst_length_out;
      if (c == 164) begin
        busy_gap = busy_out;
        gnt_gap  = grant_out;
      end
      if (c == 165) busy_idle = busy_out;
    end
    mst_update_in = 1'b0;
    chk("t1_done_at",  32'(done_at), 32'd160);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_done_val", 32'(done_val), 32'h1);
    chk("t1_rd_cnt",   32'(rd_cnt), 32'd3);
    chk("t1_rd_bad",   32'(rd_bad), 32'd0);
    chk("t1_len_mid",  32'(len_mid), 32'd32);
    chk("t1_gap_busy", 32'(busy_gap), 32'd1);
    chk("t1_gap_gnt",  32'(gnt_gap), 32'd0);
    chk("t1_idle",     32'(busy_idle), 32'd0);

    // ---- reset during a frame ----
    req_number_in[35:27] = 9'd1;
    cfg_length           = 7'd8;
    req_in               = 4'b1000;
    repeat (4) @(negedge clk);
    chk("rf_pre_grant", 32'(grant_out), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("rf_grant",  32'(grant_out), 32'd0);
    chk("rf_busy",   32'(busy_out), 32'd0);
    chk("rf_number", 32'(mst_number_out), 32'd0);
    chk("rf_length", 32'(mst_length_out), 32'd0);
    chk("rf_data",   mst_data_out, 32'd0);
    done_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (req_done_out != '0) done_cnt++;
    end
    chk("rf_no_done", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    run_frame("rf_after", 4'b1000, 32'hD3D3_0003, 1, 8, 24, 1'b1);

    // ---- all four request together ----
    req_number_in = {9'd1, 9'd1, 9'd1, 9'd1};
`ifdef MCBSP_ARB_FIXED_PRIO_EN
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    req_in = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cfg_length = 7'd8;
      run_frame($sformatf("arb%0d", k), exp_order[k],
                req_data_in[32*(k % 4) +: 32] & {32{exp_order[k][k % 4]}} |
                ({32{exp_order[k] == 4'b0001}} & 32'hA0A0_0000),
                1, 8, 24, k == 3);
    end

    // ---- empty frame on requester 2 ----
    req_number_in[26:18] = 9'd0;
    req_in = 4'b0100;
    @(negedge clk);
    chk("z_grant", 32'(grant_out), 32'h4);
    chk("z_err",   32'(req_err_out), 32'h4);
    chk("z_done",  32'(req_done_out), 32'h4);
    chk("z_en",    32'(mst_en_out), 32'd0);
    req_in     = '0;
    en_seen    = 1'b0;
    err_pulses = 0;
    busy_gap   = 1'b0;
    busy_idle  = 1'b1;
    gnt_gap    = '1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mst_en_out) en_seen = 1'b1;
      if (req_err_out != '0) err_pulses++;
      if (c == 1) gnt_gap = grant_out;
      if (c == 4) busy_gap = busy_out;
      if (c == 5) busy_idle = busy_out;
    end
    chk("z_no_en",     32'(en_seen), 32'd0);
    chk("z_err_once",  32'(err_pulses), 32'd0);
    chk("z_gap_gnt",   32'(gnt_gap), 32'd0);
    chk("z_gap_busy",  32'(busy_gap), 32'd1);
    chk("z_idle",      32'(busy_idle), 32'd0);

    // ---- short length clamped to 8 ----
    req_number_in[17:9] = 9'd2;
    cfg_length          = 7'd4;
    req_in              = 4'b0010;
    run_frame("clamp", 4'b0010, 32'hB1B1_0001, 2, 8, 32, 1'b1);
    chk("clamp_len_held", 32'(mst_length_out), 32'd8);
    chk("clamp_num_held", 32'(mst_number_out), 32'd2);
    chk("clamp_data_idle", mst_data_out, 32'd0);
    chk("clamp_gnt_idle", 32'(grant_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
